fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter OPD_WIDTH, default 32, meaning address/operand width.
REQ-002 SHALL have parameter PC_WIDTH, default 12, meaning instruction-memory address width.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-004 SHALL have port clk, input, 1, meaning single clock, all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port redirect_valid, input, 1, meaning branch/jump taken this cycle.
REQ-007 SHALL have port redirect_pc, input, OPD_WIDTH, meaning branch/jump target.
REQ-008 SHALL have port trap_valid, input, 1, meaning CSR/trap redirect this cycle.
REQ-009 SHALL have port trap_pc, input, OPD_WIDTH, meaning trap target.
REQ-010 SHALL have port imem_req_valid, output, 1, meaning fetch request valid.
REQ-011 SHALL have port imem_req_ready, input, 1, meaning memory accepts request.
REQ-012 SHALL have port imem_req_addr, output, PC_WIDTH, meaning fetch address (pc[PC_WIDTH-1:0]).
REQ-013 SHALL have port imem_rsp_valid, input, 1, meaning instruction data returned.
REQ-014 SHALL have port imem_rsp_data, input, 32, meaning returned instruction.
REQ-015 SHALL have port instr_valid, output, 1, meaning instruction presented to decode.
REQ-016 SHALL have port instr_ready, input, 1, meaning decode accepts instruction.
REQ-017 SHALL have ports instr_out (output, 32) and instr_pc (output, OPD_WIDTH), meaning presented instruction and its address.

Function
REQ-018 SHALL keep at most one imem request outstanding.
REQ-019 SHALL implement states FETCH (req_valid=1), WAIT (awaiting rsp), HOLD (instr_valid=1 from buffer), DROP (awaiting rsp to discard).
REQ-020 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-021 SHALL transition FETCH->WAIT on imem_req_ready=1 with no redirect pending or arriving.
REQ-022 SHALL on imem_rsp_valid in WAIT register data and pc into the output buffer and enter HOLD; instr_valid rises the cycle after rsp (latency 1).
REQ-023 SHALL in HOLD on instr_ready=1 enter FETCH with pc=instr_pc+4 the next cycle.
REQ-024 SHALL give trap_valid priority over redirect_valid when both are asserted.
REQ-025 SHALL on redirect in FETCH without acceptance latch target in a pending register, keep request unchanged, and enter DROP upon acceptance.
REQ-026 SHALL on redirect in FETCH coincident with acceptance, or in WAIT, enter DROP; discard next response; then enter FETCH at target.
REQ-027 SHALL on redirect in HOLD clear instr_valid next cycle and enter FETCH at target.
REQ-028 SHALL on redirect coincident with a HOLD instr_ready handshake complete the handshake and fetch from the target, not pc+4.
REQ-029 SHALL overwrite a pending target with any later redirect before the pending one is applied.
REQ-030 SHALL ignore imem_rsp_valid in FETCH and HOLD.

Reset
REQ-031 SHALL on rst_n=0 asynchronously force imem_req_valid=0, instr_valid=0, instr_out=0, instr_pc=0, pc=RESET_PC, pending cleared, state FETCH with request masked.
REQ-032 SHALL assert imem_req_valid with address RESET_PC on the first posedge after rst_n deassertion; redirects during reset are ignored.
REQ-033 SHALL on reset mid-transaction drop any outstanding response.

Configuration
REQ-034 SHALL with FETCH_MISALIGN_TRAP_EN defined raise output misalign_exc (1 bit) for one cycle and stop fetching when an applied target has bits[1:0]!=0, until the next trap_valid.
REQ-035 SHALL without FETCH_MISALIGN_TRAP_EN force target bits[1:0] to 0 and omit misalign_exc.

Structure
REQ-036 SHALL place the state enum, INSTR_WIDTH=32 and the PC increment constant 4 in shared package fetch_pkg.
REQ-037 SHALL implement the one-entry output buffer as sub-module fetch_rsp_buf.

Verification
REQ-038 SHALL test reset release: RESET_PC=0, ready=1, rsp 1 cycle later -> req addr 0,4,8 on consecutive fetches; instr_pc matches.
REQ-039 SHALL test backpressure: instr_ready=0 for 5 cycles -> instr_valid held, instr_out stable, no new request.
REQ-040 SHALL test redirect in WAIT to 0x40 -> response discarded, next req addr 0x40, no instr_valid for discarded data.
REQ-041 SHALL test simultaneous trap_pc=0x100 and redirect_pc=0x80 -> next fetch 0x100.
REQ-042 SHALL test redirect during stalled request (ready=0) -> addr unchanged until accept, then DROP, then fetch target.
REQ-043 SHALL test redirect to 0x42 -> misalign_exc=1 with macro, fetch 0x40 without.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Constants and state encoding shared by the instruction-fetch controller
//   (fetch_ctrl) and its one-entry output buffer (fetch_rsp_buf).
//
//   INSTR_WIDTH : width of one instruction word
//   PC_INC      : byte distance between sequential instructions
//   fetch_state_t / ST_* : controller state encoding
//     ST_FETCH - request presented to instruction memory
//     ST_WAIT  - request accepted, awaiting its response
//     ST_HOLD  - instruction held in the buffer, presented to decode
//     ST_DROP  - request accepted but redirected, response will be discarded
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_INC      = 4;

    // The encoding is a plain 2-bit vector so older netlists and waveform
    // decoders keep working.
    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_FETCH = 2'd0;
    localparam fetch_state_t ST_WAIT  = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;
    localparam fetch_state_t ST_DROP  = 2'd3;

endpackage : fetch_pkg

// File: rtl/fetch_rsp_buf.sv
// -----------------------------------------------------------------------------
// fetch_rsp_buf
//   One-entry buffer holding the instruction currently presented to decode.
//   A load captures data and address and raises valid; a clear drops valid.
//   Load wins if both are asserted (the controller never does that).
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   load_i         : capture load_data_i / load_pc_i, set valid
//   load_data_i    : instruction word to capture
//   load_pc_i      : address of that instruction
//   clear_i        : drop the held entry
//   valid_o        : entry valid (instr_valid)
//   data_o, pc_o   : held instruction and its address
// -----------------------------------------------------------------------------
module fetch_rsp_buf
    import fetch_pkg::*;
#(
    parameter int OPD_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic [INSTR_WIDTH-1:0] load_data_i,
    input  logic [OPD_WIDTH-1:0]   load_pc_i,
    input  logic                   clear_i,
    output logic                   valid_o,
    output logic [INSTR_WIDTH-1:0] data_o,
    output logic [OPD_WIDTH-1:0]   pc_o
);

    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] data_q,  data_d;
    logic [OPD_WIDTH-1:0]   pc_q,    pc_d;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
            pc_d    = load_pc_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values; the data/pc registers are reset too because decode
    // observes them directly and must see zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule : fetch_rsp_buf

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch controller. Issues at most one instruction-memory
//   request at a time, buffers the returned word for decode, and steers the
//   fetch stream on branch/jump redirects and traps (trap wins if both).
//
// Parameters
//   OPD_WIDTH : address/operand width
//   PC_WIDTH  : instruction-memory address width
//   RESET_PC  : first fetch address after reset
//
// Ports
//   clk, rst_n                     : clock, asynchronous active-low reset
//   redirect_valid / redirect_pc   : branch/jump taken and its target
//   trap_valid / trap_pc           : trap redirect and its target
//   imem_req_valid/ready/addr      : fetch request handshake, addr = pc[PC_WIDTH-1:0]
//   imem_rsp_valid / imem_rsp_data : returned instruction
//   instr_valid / instr_ready      : decode handshake
//   instr_out / instr_pc           : presented instruction and its address
//   misalign_exc                   : (FETCH_MISALIGN_TRAP_EN only) one-cycle
//                                    pulse when an applied target is not
//                                    word aligned
//
// Build option
//   FETCH_MISALIGN_TRAP_EN : when defined, a misaligned applied target raises
//   misalign_exc and halts fetching until the next trap_valid. When undefined,
//   target bits [1:0] are forced to zero and misalign_exc does not exist.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                   OPD_WIDTH = 32,
    parameter int                   PC_WIDTH  = 12,
    parameter logic [OPD_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [OPD_WIDTH-1:0]   redirect_pc,
    input  logic                   trap_valid,
    input  logic [OPD_WIDTH-1:0]   trap_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                   misalign_exc,
`endif
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [OPD_WIDTH-1:0]   instr_pc
);

    fetch_state_t         state_q, state_d;
    logic [OPD_WIDTH-1:0] pc_q, pc_d;
    logic [OPD_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                 pend_valid_q, pend_valid_d;
    // Low for the first cycle out of reset so the request stays masked while
    // rst_n is asserted and rises on the first clock edge afterwards.
    logic                 req_en_q, req_en_d;
    // Fetching stopped after a misaligned target; constant zero when the
    // misalign trap is not built in.
    logic                 halt_q, halt_d;

    logic                 redir_any;
    logic [OPD_WIDTH-1:0] redir_raw;
    logic [OPD_WIDTH-1:0] redir_tgt;
    logic [OPD_WIDTH-1:0] apply_tgt;
    logic                 tgt_bad;
    logic                 apply;
    logic                 buf_load;
    logic                 buf_clear;

    // Redirects are only honoured once the request path is live, which also
    // keeps the first request at RESET_PC.
    assign redir_any = req_en_q & (trap_valid | redirect_valid);
    assign redir_raw = trap_valid ? trap_pc : redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_tgt = redir_raw;
`else
    localparam logic [OPD_WIDTH-1:0] ALIGN_MASK = ~OPD_WIDTH'(3);
    assign redir_tgt = redir_raw & ALIGN_MASK;
`endif

    // A redirect arriving in the cycle a target is applied supersedes any
    // older pending target.
    assign apply_tgt = redir_any ? redir_tgt : pend_pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt_bad = |apply_tgt[1:0];
`else
    assign tgt_bad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        req_en_d     = 1'b1;
        halt_d       = halt_q;
        apply        = 1'b0;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (!req_en_q) begin
                    // first cycle after reset: request masked, nothing else
                end else if (halt_q) begin
                    // only a trap restarts fetching after a misaligned target
                    if (trap_valid) begin
                        apply = 1'b1;
                    end
                end else if (redir_any) begin
                    // The address on the bus must not change while stalled,
                    // so the target waits in the pending register.
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redir_tgt;
                    if (imem_req_ready) begin
                        state_d = ST_DROP;
                    end
                end else if (imem_req_ready) begin
                    state_d = pend_valid_q ? ST_DROP : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redir_any) begin
                    if (imem_rsp_valid) begin
                        // the stale response is here already: discard it now
                        apply = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = redir_tgt;
                        state_d      = ST_DROP;
                    end
                end else if (imem_rsp_valid) begin
                    buf_load = 1'b1;
                    state_d  = ST_HOLD;
                end
            end

            ST_DROP: begin
                if (imem_rsp_valid) begin
                    apply = 1'b1;
                end else if (redir_any) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redir_tgt;
                end
            end

            ST_HOLD: begin
                // A redirect flushes the buffer; if decode accepts in the same
                // cycle that handshake still completes, but fetch resumes at
                // the target rather than the sequential address.
                if (redir_any) begin
                    apply     = 1'b1;
                    buf_clear = 1'b1;
                end else if (instr_ready) begin
                    pc_d      = instr_pc + OPD_WIDTH'(PC_INC);
                    buf_clear = 1'b1;
                    state_d   = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (apply) begin
            pc_d         = apply_tgt;
            pend_valid_d = 1'b0;
            halt_d       = tgt_bad;
            state_d      = ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            req_en_q     <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            req_en_q     <= req_en_d;
            halt_q       <= halt_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= apply & tgt_bad;
        end
    end

    assign misalign_exc = misalign_q;
`endif

    assign imem_req_valid = (state_q == ST_FETCH) & req_en_q & ~halt_q;
    assign imem_req_addr  = pc_q[PC_WIDTH-1:0];

    fetch_rsp_buf #(
        .OPD_WIDTH (OPD_WIDTH)
    ) u_rsp_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (buf_load),
        .load_data_i (imem_rsp_data),
        .load_pc_i   (pc_q),
        .clear_i     (buf_clear),
        .valid_o     (instr_valid),
        .data_o      (instr_out),
        .pc_o        (instr_pc)
    );

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed testbench for fetch_ctrl (default parameters). Inputs change and
//   outputs are sampled on the falling clock edge; the design reacts on the
//   rising edge. Build with FETCH_MISALIGN_TRAP_EN defined to cover the
//   misalign-trap variant.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [11:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .OPD_WIDTH (32),
        .PC_WIDTH  (12),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_exc   (misalign_exc),
`endif
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: sequence did not finish, observed running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starting on a falling edge in ST_FETCH: accept the request at addr a,
    // return d one cycle later, then let decode take it.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
        check("req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("req_addr", {20'b0, imem_req_addr}, a);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("instr_valid", {31'b0, instr_valid}, 32'd1);
        check("instr_out", instr_out, d);
        check("instr_pc", instr_pc, a);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("consumed", {31'b0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_valid     = 1'b0;
        trap_pc        = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        #1 rst_n = 1'b0;

        // ---- reset: outputs cleared, redirect during reset has no effect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        repeat (2) @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);

        // ---- sequential fetch 0, 4, 8
        fetch_one(32'h0, 32'hA000_0000);
        fetch_one(32'h4, 32'hA000_0004);
        fetch_one(32'h8, 32'hA000_0008);

        // ---- decode backpressure at 0xC, plus a stray rsp ignored in HOLD
        check("bp_req_addr", {20'b0, imem_req_addr}, 32'hC);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hB00C_0000;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_instr_valid", {31'b0, instr_valid}, 32'd1);
            check("bp_instr_out", instr_out, 32'hB00C_0000);
            check("bp_no_req", {31'b0, imem_req_valid}, 32'd0);
            imem_rsp_valid = (i == 1);
            imem_rsp_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            imem_rsp_valid = 1'b0;
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("bp_next_addr", {20'b0, imem_req_addr}, 32'h10);

        // ---- redirect while waiting: response discarded, fetch 0x40
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("drop_no_req", {31'b0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0010;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("drop_no_instr", {31'b0, instr_valid}, 32'd0);
        fetch_one(32'h40, 32'hC000_0040);

        // ---- trap beats redirect, arriving during a HOLD handshake
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hC000_0044;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("trap_hold_pc", instr_pc, 32'h44);
        trap_valid     = 1'b1;
        trap_pc        = 32'h100;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        instr_ready    = 1'b1;
        @(negedge clk);
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        check("trap_flush", {31'b0, instr_valid}, 32'd0);
        check("trap_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("trap_addr", {20'b0, imem_req_addr}, 32'h100);

        // ---- redirect while stalled; a later redirect overwrites the first
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("stall_addr1", {20'b0, imem_req_addr}, 32'h100);
        redirect_pc    = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("stall_addr2", {20'b0, imem_req_addr}, 32'h100);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("stall_drop", {31'b0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0100;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("stall_no_instr", {31'b0, instr_valid}, 32'd0);
        check("stall_target", {20'b0, imem_req_addr}, 32'h300);

        // ---- misaligned target 0x42, redirect coincident with the response
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0300;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        check("mis_no_instr", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_exc", {31'b0, misalign_exc}, 32'd1);
        check("mis_halt", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("mis_exc_pulse", {31'b0, misalign_exc}, 32'd0);
        check("mis_still_halt", {31'b0, imem_req_valid}, 32'd0);
        trap_valid = 1'b1;
        trap_pc    = 32'h80;
        @(negedge clk);
        trap_valid = 1'b0;
        check("mis_resume", {31'b0, imem_req_valid}, 32'd1);
        check("mis_resume_addr", {20'b0, imem_req_addr}, 32'h80);
`else
        check("mis_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("mis_aligned_addr", {20'b0, imem_req_addr}, 32'h40);
`endif

        // ---- reset mid-transaction: late response must not surface
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("mrst_instr_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_FFFF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("mrst_no_instr", {31'b0, instr_valid}, 32'd0);
        check("mrst_req_valid2", {31'b0, imem_req_valid}, 32'd1);
        check("mrst_addr", {20'b0, imem_req_addr}, 32'h0);
        fetch_one(32'h0, 32'hE000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_ctrl
